// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline with a multi-cycle divider.
// Resolves load-use hazards, divider stalls and flushes; outputs are decoded combinationally from state.
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_read,
    input  logic       id_rt_read,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg_addr,
    input  logic       ex_is_div,
    input  logic       flush_i,
    output logic [5:0] stall_o,
    output logic       idex_bubble_o,
    output logic       exmem_bubble_o,
    output logic       flush_o,
    output logic       div_start_o,
    output logic       div_abort_o,
    output logic       div_busy_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000011;
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] CNT_LOAD   = 6'(DIV_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_nxt_s;
    logic       load_use_s;

    // A source operand collides with a pending load destination; r0 never does.
    function automatic logic src_hazard(
        input logic       rd,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return rd && (src == dst) && (dst != 5'd0);
    endfunction

    // Load-use hazard detection for the instruction in ID.
    always_comb begin
        load_use_s = ex_mem_read &&
                     (src_hazard(id_rs_read, id_rs_addr, ex_write_reg_addr) ||
                      src_hazard(id_rt_read, id_rt_addr, ex_write_reg_addr));
    end

    // Next-state and down-counter logic; flush wins over every state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush_i) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ex_is_div) begin
                        state_nxt_s = DIV_BUSY;
                        cnt_nxt_s   = CNT_LOAD;
                    end else begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 6'd0;
                    end
                end
                DIV_BUSY: begin
                    // cnt==0 cannot occur in normal operation; treat it as terminal.
                    if (cnt_r <= 6'd1) begin
                        state_nxt_s = DIV_DONE;
                        cnt_nxt_s   = 6'd0;
                    end else begin
                        state_nxt_s = DIV_BUSY;
                        cnt_nxt_s   = cnt_r - 6'd1;
                    end
                end
                DIV_DONE: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 6'd0;
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 6'd0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output decode: reset silences everything, then flush, then divider, then load-use.
    always_comb begin
        stall_o        = STALL_NONE;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        flush_o        = 1'b0;
        div_start_o    = 1'b0;
        div_abort_o    = 1'b0;
        div_busy_o     = 1'b0;
        if (rst) begin
            stall_o = STALL_NONE;
        end else if (flush_i) begin
            flush_o     = 1'b1;
            div_abort_o = (state_r == DIV_BUSY);
            div_busy_o  = (state_r == DIV_BUSY);
        end else begin
            case (state_r)
                IDLE: begin
                    if (ex_is_div) begin
                        stall_o        = STALL_DIV;
                        exmem_bubble_o = 1'b1;
                        div_start_o    = 1'b1;
                    end else if (load_use_s) begin
                        stall_o       = STALL_LU;
                        idex_bubble_o = 1'b1;
                    end else begin
                        stall_o = STALL_NONE;
                    end
                end
                DIV_BUSY: begin
                    stall_o        = STALL_DIV;
                    exmem_bubble_o = 1'b1;
                    div_busy_o     = 1'b1;
                end
                DIV_DONE: begin
                    // The DIV is still in EX here, so ex_is_div must not restart it.
                    if (load_use_s) begin
                        stall_o       = STALL_LU;
                        idex_bubble_o = 1'b1;
                    end else begin
                        stall_o = STALL_NONE;
                    end
                end
                default: begin
                    stall_o = STALL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl (DIV_CYCLES=4) with a scoreboard queue of expected outputs.
module tb_pipeline_ctrl;

    typedef struct {
        string      name;
        logic       rst;
        logic       flush;
        logic       is_div;
        logic       mem_read;
        logic [4:0] ex_wr;
        logic [4:0] rs;
        logic       rs_rd;
        logic [4:0] rt;
        logic       rt_rd;
        logic [11:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, ex_write_reg_addr;
    logic       id_rs_read, id_rt_read, ex_mem_read, ex_is_div, flush_i;
    logic [5:0] stall_o;
    logic       idex_bubble_o, exmem_bubble_o, flush_o, div_start_o, div_abort_o, div_busy_o;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pipeline_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read),
        .ex_mem_read(ex_mem_read), .ex_write_reg_addr(ex_write_reg_addr),
        .ex_is_div(ex_is_div), .flush_i(flush_i),
        .stall_o(stall_o), .idex_bubble_o(idex_bubble_o), .exmem_bubble_o(exmem_bubble_o),
        .flush_o(flush_o), .div_start_o(div_start_o), .div_abort_o(div_abort_o),
        .div_busy_o(div_busy_o)
    );

    always #5 clk = ~clk;

    // expected = {stall[5:0], idex, exmem, flush, start, abort, busy}
    function automatic logic [11:0] e(input logic [5:0] st, input logic idex, input logic exm,
                                      input logic fl, input logic start, input logic abort,
                                      input logic busy);
        return {st, idex, exm, fl, start, abort, busy};
    endfunction

    localparam logic [11:0] E_NONE  = 12'b000000_000000;
    localparam logic [11:0] E_LU    = 12'b000011_100000;
    localparam logic [11:0] E_START = 12'b001111_010100;
    localparam logic [11:0] E_BUSY  = 12'b001111_010001;
    localparam logic [11:0] E_FL    = 12'b000000_001000;
    localparam logic [11:0] E_FLB   = 12'b000000_001011;

    function automatic vec_t mk(input string nm, input logic r, input logic fl, input logic dv,
                                input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                                input logic rsr, input logic [4:0] rt, input logic rtr,
                                input logic [11:0] ex);
        vec_t v;
        v.name = nm; v.rst = r; v.flush = fl; v.is_div = dv; v.mem_read = mr; v.ex_wr = wr;
        v.rs = rs; v.rs_rd = rsr; v.rt = rt; v.rt_rd = rtr; v.exp = ex;
        return v;
    endfunction

    // Plain cycle with no hazard inputs, only rst/flush/div controls.
    function automatic vec_t pl(input string nm, input logic r, input logic fl, input logic dv,
                                input logic [11:0] ex);
        return mk(nm, r, fl, dv, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ex);
    endfunction

    // Load-use hazard on rs (r5) with optional rst/flush/div controls.
    function automatic vec_t lu(input string nm, input logic r, input logic fl, input logic dv,
                                input logic [11:0] ex);
        return mk(nm, r, fl, dv, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, ex);
    endfunction

    task automatic apply(input vec_t v);
        vec_t x;
        logic [11:0] act;
        rst = v.rst; flush_i = v.flush; ex_is_div = v.is_div; ex_mem_read = v.mem_read;
        ex_write_reg_addr = v.ex_wr; id_rs_addr = v.rs; id_rs_read = v.rs_rd;
        id_rt_addr = v.rt; id_rt_read = v.rt_rd;
        sb.push_back(v);
        @(negedge clk);
        x = sb.pop_front();
        act = {stall_o, idex_bubble_o, exmem_bubble_o, flush_o, div_start_o, div_abort_o, div_busy_o};
        n_vec++;
        if (act !== x.exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", x.name, act, x.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wind_down(input string nm);
        for (int i = 0; i < 3; i++) apply(pl({nm, "_busy"}, 1'b0, 1'b0, 1'b1, E_BUSY));
        apply(pl({nm, "_done"}, 1'b0, 1'b0, 1'b1, E_NONE));
    endtask

    initial begin
        tbl.push_back(lu("reset_lu_div", 1'b1, 1'b0, 1'b1, E_NONE));
        tbl.push_back(lu("reset_flush", 1'b1, 1'b1, 1'b1, E_NONE));
        tbl.push_back(lu("lu_rs", 1'b0, 1'b0, 1'b0, E_LU));
        tbl.push_back(pl("lu_release", 1'b0, 1'b0, 1'b0, E_NONE));
        tbl.push_back(mk("lu_r0", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, E_NONE));
        tbl.push_back(mk("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, E_LU));
        tbl.push_back(mk("lu_rt_noread", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, E_NONE));
        tbl.push_back(mk("lu_not_load", 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, E_NONE));
        tbl.push_back(mk("lu_addr_diff", 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 1'b1, 5'd10, 1'b1, E_NONE));
        tbl.push_back(lu("flush_idle", 1'b0, 1'b1, 1'b1, E_FL));
        tbl.push_back(lu("div_start_lu", 1'b0, 1'b0, 1'b1, E_START));
        tbl.push_back(lu("busy_lu_c3", 1'b0, 1'b0, 1'b1, E_BUSY));
        tbl.push_back(lu("busy_lu_c2", 1'b0, 1'b0, 1'b1, E_BUSY));
        tbl.push_back(pl("busy_c1", 1'b0, 1'b0, 1'b1, E_BUSY));
        tbl.push_back(pl("div_done", 1'b0, 1'b0, 1'b1, E_NONE));
        tbl.push_back(pl("idle_after", 1'b0, 1'b0, 1'b0, E_NONE));

        rst = 1'b1; flush_i = 1'b0; ex_is_div = 1'b0; ex_mem_read = 1'b0;
        ex_write_reg_addr = 5'd0; id_rs_addr = 5'd0; id_rs_read = 1'b0;
        id_rt_addr = 5'd0; id_rt_read = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Load-use during DIV_DONE stalls only the front end.
        apply(pl("s1_start", 1'b0, 1'b0, 1'b1, E_START));
        for (int i = 0; i < 3; i++) apply(pl("s1_busy", 1'b0, 1'b0, 1'b1, E_BUSY));
        apply(lu("s1_done_lu", 1'b0, 1'b0, 1'b1, E_LU));
        apply(pl("s1_idle", 1'b0, 1'b0, 1'b0, E_NONE));

        // Flush at cnt=2 aborts the divider.
        apply(pl("s2_start", 1'b0, 1'b0, 1'b1, E_START));
        apply(pl("s2_busy_c3", 1'b0, 1'b0, 1'b1, E_BUSY));
        apply(lu("s2_flush_c2", 1'b0, 1'b1, 1'b1, E_FLB));
        apply(pl("s2_idle", 1'b0, 1'b0, 1'b0, E_NONE));

        // Flush in DIV_DONE: no abort.
        apply(pl("s3_start", 1'b0, 1'b0, 1'b1, E_START));
        for (int i = 0; i < 3; i++) apply(pl("s3_busy", 1'b0, 1'b0, 1'b1, E_BUSY));
        apply(pl("s3_flush_done", 1'b0, 1'b1, 1'b1, E_FL));
        apply(pl("s3_idle", 1'b0, 1'b0, 1'b0, E_NONE));

        // Reset mid-DIV_BUSY (even with flush) gives silent return to IDLE.
        apply(pl("s4_start", 1'b0, 1'b0, 1'b1, E_START));
        apply(lu("s4_rst_busy", 1'b1, 1'b1, 1'b1, E_NONE));
        apply(pl("s4_idle", 1'b0, 1'b0, 1'b0, E_NONE));
        apply(pl("s4_restart", 1'b0, 1'b0, 1'b1, E_START));
        wind_down("s4");

        // Flush blocks a start; the DIV then starts once flush drops.
        apply(pl("s5_flush_start", 1'b0, 1'b1, 1'b1, E_FL));
        apply(pl("s5_start", 1'b0, 1'b0, 1'b1, E_START));
        wind_down("s5");
        apply(lu("s5_idle_lu", 1'b0, 1'b0, 1'b0, e(6'b000011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning divider latency in cycles from div_start_o to result ready (legal range 2..63).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port id_rs_addr  input  5  rs register address of instruction in ID.
REQ-005 SHALL have port id_rt_addr  input  5  rt register address of instruction in ID.
REQ-006 SHALL have port id_rs_read  input  1  ID instruction reads rs.
REQ-007 SHALL have port id_rt_read  input  1  ID instruction reads rt.
REQ-008 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-009 SHALL have port ex_write_reg_addr  input  5  destination register of EX instruction.
REQ-010 SHALL have port ex_is_div  input  1  instruction in EX is DIV/DIVU.
REQ-011 SHALL have port flush_i  input  1  exception/redirect flush request.
REQ-012 SHALL have port stall_o  output  6  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
REQ-013 SHALL have port idex_bubble_o  output  1  ID/EX register loads all-zero (NOP) this cycle.
REQ-014 SHALL have port exmem_bubble_o  output  1  EX/MEM register loads all-zero this cycle.
REQ-015 SHALL have port flush_o  output  1  clear IF/ID, ID/EX, EX/MEM to zero this cycle.
REQ-016 SHALL have port div_start_o  output  1  one-cycle divider start pulse.
REQ-017 SHALL have port div_abort_o  output  1  one-cycle divider abort pulse.
REQ-018 SHALL have port div_busy_o  output  1  divider sequence in progress (state DIV_BUSY).

Function
REQ-019 SHALL hold FSM state {IDLE, DIV_BUSY, DIV_DONE} and 6-bit down-counter cnt as the only registered state; all outputs are combinational from state, cnt and inputs.
REQ-020 SHALL define load_use = ex_mem_read & (ex_write_reg_addr != 0) & ((id_rs_read & id_rs_addr == ex_write_reg_addr) | (id_rt_read & id_rt_addr == ex_write_reg_addr)).
REQ-021 SHALL, in IDLE with ex_is_div=1 and flush_i=0: assert div_start_o, stall_o=6'b001111, exmem_bubble_o=1; next state DIV_BUSY, cnt <= DIV_CYCLES-1.
REQ-022 SHALL, in DIV_BUSY: stall_o=6'b001111, exmem_bubble_o=1, div_busy_o=1; cnt decrements each cycle; when cnt==1 next state DIV_DONE.
REQ-023 SHALL, in DIV_DONE: release all stalls (stall_o=0 unless load_use), exmem_bubble_o=0, ignore ex_is_div (same instruction still present); next state IDLE.
REQ-024 SHALL, when load_use=1 and no divider stall applies: stall_o=6'b000011, idex_bubble_o=1 for exactly that cycle; no registered state.
REQ-025 SHALL give divider stall priority over load_use; idex_bubble_o=0 whenever stall bit2 is set.
REQ-026 SHALL, on flush_i=1 (any state): flush_o=1, stall_o=0, both bubbles 0, div_start_o=0; next state IDLE, cnt <= 0; div_abort_o=1 if state is DIV_BUSY.
REQ-027 SHALL keep flush_o, div_start_o and div_abort_o mutually consistent: div_start_o never asserted in a cycle with flush_i=1.
REQ-028 SHALL issue div_start_o at most once per DIV instruction; divider latency from div_start_o to DIV_DONE is exactly DIV_CYCLES cycles.
REQ-029 SHALL treat register 0 as never hazardous.

Reset
REQ-030 SHALL, while rst=1 at a clock edge: state <= IDLE, cnt <= 0.
REQ-031 SHALL force, during any cycle with rst=1: stall_o=0, idex_bubble_o=0, exmem_bubble_o=0, flush_o=0, div_start_o=0, div_abort_o=0, div_busy_o=0, regardless of other inputs.
REQ-032 SHALL, on rst asserted mid-DIV_BUSY, return to IDLE without asserting div_abort_o.

Verification
REQ-033 SHALL cover: ex_mem_read=1, ex_write_reg_addr=5, id_rs_read=1, id_rs_addr=5 -> stall_o=000011, idex_bubble_o=1 for one cycle; same with addr 0 -> no stall.
REQ-034 SHALL cover: ex_is_div=1 in IDLE, DIV_CYCLES=4 -> div_start_o 1 cycle, stall_o=001111 for 4 cycles, then one DIV_DONE cycle with stall_o=0, then IDLE, no second div_start_o.
REQ-035 SHALL cover: load_use and DIV_BUSY simultaneously -> stall_o=001111, idex_bubble_o=0.
REQ-036 SHALL cover: flush_i=1 at cnt=2 in DIV_BUSY -> flush_o=1, div_abort_o=1 one cycle, next cycle IDLE, stall_o=0.
REQ-037 SHALL cover: rst=1 during DIV_BUSY -> all outputs 0 that cycle, IDLE afterwards, div_abort_o never asserted.
